// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipeline_pkg
// Brief    : Shared MEM-stage types: access FSM states, access-size encodings,
//            byte-lane geometry and a sign-extension helper.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  function automatic logic [31:0] sext_byte(input logic [LANE_W-1:0] b);
    return {{(32-LANE_W){b[LANE_W-1]}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Brief    : Combinational lane steering for data-memory byte/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
  import pipeline_pkg::*;
(
  input  logic        mem_type,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [LANE_W-1:0] w_lane_byte;

  always_comb begin
    w_lane_byte = rdata[7:0];
    case (lane)
      2'd0:    w_lane_byte = rdata[7:0];
      2'd1:    w_lane_byte = rdata[15:8];
      2'd2:    w_lane_byte = rdata[23:16];
      default: w_lane_byte = rdata[31:24];
    endcase
  end

  // Byte stores replicate the byte on every lane; the enable picks the lane.
  always_comb begin
    if (mem_type == MEM_BYTE) begin
      be        = 4'b0001 << lane;
      wdata     = {NUM_LANES{store_data[LANE_W-1:0]}};
      load_data = sext_byte(w_lane_byte);
    end else begin
      be        = 4'b1111;
      wdata     = store_data;
      load_data = rdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MIPS MEM stage: redirect, req/ack data access, forwarding probe,
//            MEM/WB register. MEM_ALIGN_CHECK_EN suppresses misaligned words.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        alu_zero,
  input  logic [31:0] pc_branch,
  input  logic [31:0] pc_jump,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic        mem_type,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        mem_busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_out,
  output logic [4:0]  wb_reg_addr,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic        wb_misalign
);

  mem_state_e  r_state;
  mem_state_e  w_state_next;
  logic        w_access;
  logic        w_misalign;
  logic        w_eff_access;
  logic        w_capture;
  logic [31:0] r_hold;
  logic [31:0] w_rdata_sel;
  logic [31:0] w_load_data;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;

  assign w_access = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & (mem_type == MEM_WORD) & (alu_out[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_eff_access = w_access & ~w_misalign;

  assign pc_src    = (is_branch & alu_zero) | is_jump;
  assign pc_target = is_jump ? pc_jump : pc_branch;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_eff_access) begin
          if (dmem_ack) w_state_next = we ? ST_IDLE : ST_DONE;
          else          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) w_state_next = we ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (we) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // DONE parks a completed access until the pipeline advances; no bus activity.
  always_comb begin
    dmem_req  = 1'b0;
    w_capture = 1'b0;
    mem_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        dmem_req  = w_eff_access;
        w_capture = w_eff_access & dmem_ack;
        mem_busy  = w_eff_access & ~dmem_ack;
      end
      ST_WAIT: begin
        dmem_req  = 1'b1;
        w_capture = dmem_ack;
        mem_busy  = w_eff_access & ~dmem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)          r_hold <= 32'd0;
    else if (w_capture) r_hold <= dmem_rdata;
  end

  assign w_rdata_sel = (r_state == ST_DONE) ? r_hold : dmem_rdata;

  mem_align u_align (
    .mem_type   (mem_type),
    .lane       (alu_out[1:0]),
    .store_data (data_t),
    .rdata      (w_rdata_sel),
    .be         (w_be),
    .wdata      (w_wdata),
    .load_data  (w_load_data)
  );

  assign dmem_we    = mem_write;
  assign dmem_addr  = (mem_type == MEM_BYTE) ? alu_out : {alu_out[31:2], 2'b00};
  assign dmem_be    = w_be;
  assign dmem_wdata = mem_write ? w_wdata : 32'd0;

  assign reg_probe   = reg_addr;
  assign data_probe  = mem_to_reg ? w_load_data : alu_out;
  assign write_probe = reg_write & ~mem_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_mem_data   <= 32'd0;
      wb_alu_out    <= 32'd0;
      wb_reg_addr   <= 5'd0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else if (we) begin
      wb_mem_data   <= w_load_data;
      wb_alu_out    <= alu_out;
      wb_reg_addr   <= reg_addr;
      wb_reg_write  <= reg_write & ~w_misalign;
      wb_mem_to_reg <= mem_to_reg;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)   wb_misalign <= 1'b0;
    else if (we) wb_misalign <= w_misalign;
  end
`else
  assign wb_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Randomized self-checking bench for mem_stage with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, is_branch, is_jump, alu_zero;
  logic [31:0] pc_branch, pc_jump;
  logic        mem_read, mem_write, mem_to_reg, reg_write, mem_type;
  logic [31:0] alu_out, data_t;
  logic [4:0]  reg_addr;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        mem_busy, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [4:0]  reg_probe;
  logic [31:0] data_probe;
  logic        write_probe;
  logic [31:0] wb_mem_data, wb_alu_out;
  logic [4:0]  wb_reg_addr;
  logic        wb_reg_write, wb_mem_to_reg, wb_misalign;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .we(we),
    .is_branch(is_branch), .is_jump(is_jump), .alu_zero(alu_zero),
    .pc_branch(pc_branch), .pc_jump(pc_jump),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_type(mem_type),
    .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
    .pc_src(pc_src), .pc_target(pc_target), .mem_busy(mem_busy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe),
    .wb_mem_data(wb_mem_data), .wb_alu_out(wb_alu_out), .wb_reg_addr(wb_reg_addr),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_misalign(wb_misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem_model [0:63];
  logic        align_check = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    we = 1'b0; is_branch = 1'b0; is_jump = 1'b0; alu_zero = 1'b0;
    pc_branch = 32'd0; pc_jump = 32'd0;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    mem_type = 1'b0; alu_out = 32'd0; data_t = 32'd0; reg_addr = 5'd0;
    dmem_rdata = 32'd0; dmem_ack = 1'b0;
  endtask

  // kind: 0 alu, 1 lw, 2 lb, 3 sw, 4 sb. k = ack latency, stall = extra we=0 cycles.
  // Called and returns at a negative clock edge.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] dt,
                         input int k, input int stall);
    logic        is_load, is_store, byte_acc, mis, eff, acked, we_now, ack_now, busy_exp, done_acc;
    logic [1:0]  lane;
    logic [5:0]  idx;
    logic [7:0]  byte_v;
    logic [31:0] word_now, exp_load, exp_addr, exp_wdata, exp_target;
    logic [3:0]  exp_be;
    int          waited, stall_left;
    is_load  = (kind == 1) || (kind == 2);
    is_store = (kind == 3) || (kind == 4);
    byte_acc = (kind == 2) || (kind == 4);
    lane     = addr[1:0];
    idx      = addr[7:2];
    mis      = align_check && (is_load || is_store) && !byte_acc && (lane != 2'b00);
    eff      = (is_load || is_store) && !mis;

    mem_read = is_load; mem_write = is_store; mem_type = byte_acc; mem_to_reg = is_load;
    reg_write = 1'($urandom_range(0, 1)); reg_addr = 5'($urandom);
    alu_out = addr; data_t = dt;
    is_branch = 1'($urandom_range(0, 1)); is_jump = 1'($urandom_range(0, 1));
    alu_zero = 1'($urandom_range(0, 1));
    pc_branch = $urandom; pc_jump = $urandom;

    word_now   = mem_model[idx];
    byte_v     = 8'(word_now >> (8 * lane));
    exp_load   = byte_acc ? 32'($signed(byte_v)) : word_now;
    exp_addr   = byte_acc ? addr : (addr & ~32'd3);
    exp_be     = byte_acc ? 4'(1 << lane) : 4'hF;
    exp_wdata  = !is_store ? 32'd0 : (byte_acc ? 32'(dt[7:0]) * 32'h0101_0101 : dt);
    exp_target = is_jump ? pc_jump : pc_branch;

    acked = 1'b0; waited = 0; stall_left = stall; we_now = 1'b0;
    for (int cyc = 0; cyc < 40 && !we_now; cyc++) begin
      ack_now  = eff && !acked && (waited >= k);
      busy_exp = eff && !acked && !ack_now;
      done_acc = !eff || acked || ack_now;
      dmem_ack   = ack_now | (!eff && 1'($urandom_range(0, 1)));
      dmem_rdata = (ack_now && is_load) ? word_now : $urandom;
      if (done_acc && stall_left == 0) we_now = 1'b1;
      else if (done_acc) stall_left--;
      we = we_now;
      #1;
      if (cyc == 0) begin
        check_val("pc_src", 32'(pc_src), 32'((is_branch & alu_zero) | is_jump));
        check_val("pc_target", pc_target, exp_target);
        check_val("reg_probe", 32'(reg_probe), 32'(reg_addr));
      end
      check_val("mem_busy", 32'(mem_busy), 32'(busy_exp));
      check_val("dmem_req", 32'(dmem_req), 32'(eff && !acked));
      check_val("write_probe", 32'(write_probe), 32'(reg_write & !busy_exp));
      if (eff && !acked) begin
        check_val("dmem_addr", dmem_addr, exp_addr);
        check_val("dmem_be", 32'(dmem_be), 32'(exp_be));
        check_val("dmem_wdata", dmem_wdata, exp_wdata);
        check_val("dmem_we", 32'(dmem_we), 32'(is_store));
      end
      if (we_now && is_load && !mis) check_val("data_probe_load", data_probe, exp_load);
      if (we_now && !is_load)        check_val("data_probe_alu", data_probe, addr);
      @(posedge clk);
      if (ack_now) begin
        acked = 1'b1;
        if (is_store && byte_acc)
          mem_model[idx] = (word_now & ~(32'hFF << (8 * lane))) | (32'(dt[7:0]) << (8 * lane));
        else if (is_store)
          mem_model[idx] = dt;
      end else if (eff && !acked) begin
        waited++;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    if (!we_now) check_val("txn_timeout", 32'd0, 32'd1);
    check_val("wb_alu_out", wb_alu_out, addr);
    check_val("wb_reg_addr", 32'(wb_reg_addr), 32'(reg_addr));
    check_val("wb_reg_write", 32'(wb_reg_write), 32'(reg_write & !mis));
    check_val("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(is_load));
    check_val("wb_misalign", 32'(wb_misalign), 32'(mis));
    if (is_load && !mis) check_val("wb_mem_data", wb_mem_data, exp_load);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef MEM_ALIGN_CHECK_EN
    align_check = 1'b1;
`endif
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
    zero_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_dmem_req", 32'(dmem_req), 32'd0);
    check_val("rst_mem_busy", 32'(mem_busy), 32'd0);
    check_val("rst_wb_mem_data", wb_mem_data, 32'd0);
    check_val("rst_wb_alu_out", wb_alu_out, 32'd0);
    check_val("rst_wb_ctrl", 32'({wb_reg_addr, wb_reg_write, wb_mem_to_reg, wb_misalign}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed examples
    mem_model[6'h00] = 32'hDEAD_BEEF;
    run_txn(1, 32'h0000_0100, 32'd0, 0, 0);
    run_txn(4, 32'h0000_0203, 32'h0000_00A5, 0, 0);
    mem_model[6'h00] = 32'h0000_8000;
    run_txn(2, 32'h0000_0201, 32'd0, 3, 0);
    run_txn(1, 32'h0000_0204, 32'd0, 0, 2);
    run_txn(2, 32'h0000_0206, 32'd0, 2, 1);
    run_txn(1, 32'h0000_0102, 32'd0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      run_txn(int'($urandom_range(0, 4)), 32'h0000_0200 | 32'($urandom_range(0, 255)),
              $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Reset while an access is stuck in WAIT
    mem_read = 1'b1; mem_to_reg = 1'b1; mem_type = 1'b0; alu_out = 32'h0000_0210;
    reg_write = 1'b1; reg_addr = 5'd7; dmem_ack = 1'b0; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_val("wait_req", 32'(dmem_req), 32'd1);
    zero_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_val("wait_rst_req", 32'(dmem_req), 32'd0);
    check_val("wait_rst_wb_alu", wb_alu_out, 32'd0);
    check_val("wait_rst_wb_ctrl", 32'({wb_reg_addr, wb_reg_write, wb_mem_to_reg}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset out of DONE must bring the FSM back to IDLE
    mem_read = 1'b1; mem_to_reg = 1'b1; mem_type = 1'b0; alu_out = 32'h0000_0220;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_0000;
    #1;
    check_val("done_req", 32'(dmem_req), 32'd0);
    check_val("done_hold", data_probe, 32'h1234_5678);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("done_rst_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_val("done_rst_wb", wb_mem_data, 32'hFFFF_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline: the consumer of the EX/MEM pipeline register. It resolves branch/jump redirection from the EX results and runs loads and stores on the data-memory bus with a req/ack handshake. It stalls the pipeline while an access is outstanding, publishes a forwarding probe, and registers results into the MEM/WB pipeline register.

## Interface
- No parameters; widths fixed at 32-bit data/address, 5-bit register ids.
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset.
- we  in  1  MEM/WB register write enable (pipeline advance) from the hazard unit.
- is_branch, is_jump, alu_zero  in  1  control from EX/MEM.
- pc_branch, pc_jump  in  32  redirect targets.
- mem_read, mem_write, mem_to_reg, reg_write  in  1  access and writeback control.
- mem_type  in  1  0 = word, 1 = byte.
- alu_out  in  32  result or effective address.
- data_t  in  32  store data.
- reg_addr  in  5  destination register.
- pc_src  out  1  redirect fetch: (is_branch & alu_zero) | is_jump.
- pc_target  out  32  is_jump ? pc_jump : pc_branch.
- mem_busy  out  1  stall request to the hazard unit.
- dmem_req, dmem_we  out  1  bus request and write strobe.
- dmem_addr, dmem_wdata  out  32  bus address and write data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete.
- reg_probe  out  5  reg_addr.
- data_probe  out  32  mem_to_reg ? load_data : alu_out.
- write_probe  out  1  reg_write & ~mem_busy.
- wb_mem_data, wb_alu_out  out  32  MEM/WB registered load data and ALU result.
- wb_reg_addr  out  5  MEM/WB registered destination register.
- wb_reg_write, wb_mem_to_reg, wb_misalign  out  1  MEM/WB registered control.

## Operation
- access = mem_read | mem_write. FSM states: IDLE, WAIT, DONE.
- IDLE: if access, then dmem_req = 1. With ack in the same cycle, the access is complete. Without ack, go to WAIT.
- WAIT: dmem_req = 1 and the bus outputs are held. On ack, capture dmem_rdata into the hold register. Then go to IDLE if we = 1, else go to DONE.
- IDLE with ack and we = 0: capture into the hold register and go to DONE.
- DONE: dmem_req = 0. load_data comes from the hold register. On we = 1, go to IDLE.
- mem_busy = access & ~dmem_ack & (state != DONE). EX/MEM inputs are held stable while busy.
- Word access: dmem_addr = {alu_out[31:2], 2'b00}, dmem_be = 4'b1111, dmem_wdata = data_t.
- Byte access: dmem_addr = alu_out. Lane n = alu_out[1:0] (little-endian, lane n = bits 8n+7:8n). dmem_be = 1 << n, dmem_wdata = {4{data_t[7:0]}}.
- Byte load data is sign-extended from lane n.
- dmem_we = mem_write. dmem_wdata = 0 on reads.
- On we = 1, the MEM/WB register latches alu_out, load_data, reg_addr, reg_write, mem_to_reg and misalign.
- pc_src and pc_target are purely combinational.

## Timing
- Reset: state IDLE, hold register 0, all wb_* outputs 0. Combinational outputs follow the (reset-zeroed) inputs, so dmem_req = 0.
- Zero-wait memory: no stall; EX/MEM to MEM/WB latency is 1 cycle.
- k wait cycles: mem_busy is high for k cycles.
- Reset during WAIT: the FSM abandons the access and dmem_req drops on the next cycle. The memory must tolerate an abandoned request.
- A late ack arriving in IDLE with no access is ignored.
- Non-access instructions never touch the bus.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Misaligned word accesses (mem_type = 0, alu_out[1:0] != 0) issue no dmem_req and are not busy.
  - misalign is high and is latched to wb_misalign.
  - wb_reg_write is forced to 0.
- MEM_ALIGN_CHECK_EN undefined: alu_out[1:0] is ignored for words and wb_misalign is tied to 0.

## Structure
- pipeline_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - the MEM_WORD/MEM_BYTE encodings;
  - the lane-width constants.
- Sub-module mem_align: a combinational lane steerer generating be and wdata for stores and extracting/sign-extending load data. The FSM and registers stay in mem_stage.

## Test plan
- Zero-wait lw, alu_out 0x100, rdata 0xDEADBEEF, ack same cycle -> mem_busy never high; wb_mem_data = 0xDEADBEEF one cycle later.
- sb with data_t 0x000000A5 at addr 0x203 -> dmem_be = 4'b1000, dmem_wdata = 0xA5A5A5A5, dmem_we = 1.
- lb at 0x201 with rdata 0x0000_8000, ack after 3 cycles -> mem_busy high for 3 cycles, req held; wb_mem_data = 0xFFFFFF80.
- Ack while we = 0 -> DONE, data held; on we pulse wb_mem_data = captured value and state returns to IDLE.
- Branch with alu_zero = 1, pc_branch 0x40 -> pc_src = 1, pc_target = 0x40. Jump to 0x80 -> pc_target = 0x80.
- Reset asserted in WAIT -> dmem_req 0 next cycle, wb_* = 0. With MEM_ALIGN_CHECK_EN, lw at 0x102 -> no req, wb_misalign = 1, wb_reg_write = 0.
